// File: rtl/dn_loader_ctrl.sv
// HPS ioctl download sequencer: steers BIOS/font bytes into the memory write
// port through a one-entry buffer and holds the system in reset around a load.
module dn_loader_ctrl #(
    parameter int ADDR_W      = 14,
    parameter int BIOS_SIZE   = 16384,
    parameter int FONT_SIZE   = 2048,
    parameter int HOLD_CYCLES = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic              ioctl_wait,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [1:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              sys_reset,
    output logic              dn_active,
    output logic              dn_error,
    output logic [24:0]       dn_count
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, HOLD} state_t;

    state_t     state, state_next;
    logic       idx;
    logic [7:0] hold_cnt;
    logic       start, complete, blocked, in_range, capture, drop;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        start      = ioctl_download && (ioctl_index < 8'd2);
        complete   = mem_valid && mem_ready;
        blocked    = mem_valid && !mem_ready;
        in_range   = ioctl_addr < (idx ? 25'(FONT_SIZE) : 25'(BIOS_SIZE));
        capture    = 1'b0;
        drop       = 1'b0;
        state_next = state;

        // A strobe that cannot land (out of range, or buffer stalled) is dropped and flagged.
        if ((state == LOAD || state == DRAIN) && ioctl_wr) begin
            if (in_range && !blocked) capture = 1'b1;
            else                      drop    = 1'b1;
        end

        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (!ioctl_download) state_next = DRAIN;
            DRAIN:   if (!mem_valid && !capture) state_next = HOLD;
            HOLD: begin
                if (start)               state_next = LOAD;
                else if (hold_cnt == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sys_reset <= 1'b1;
        end else begin
            state     <= state_next;
            sys_reset <= (state_next != IDLE);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            idx       <= 1'b0;
            hold_cnt  <= '0;
            mem_valid <= 1'b0;
            mem_sel   <= '0;
            mem_addr  <= '0;
            mem_data  <= '0;
            dn_error  <= 1'b0;
            dn_count  <= '0;
        end else begin
            if (complete) begin
                mem_valid <= 1'b0;
                if (dn_count != '1) dn_count <= dn_count + 25'd1;
            end
            // Capture after completion so a back-to-back strobe keeps valid high.
            if (capture) begin
                mem_valid <= 1'b1;
                mem_addr  <= ioctl_addr[ADDR_W-1:0];
                mem_data  <= ioctl_dout;
                mem_sel   <= idx ? 2'b10 : 2'b01;
            end
            if (drop) dn_error <= 1'b1;

            if (state == DRAIN && state_next == HOLD)
                hold_cnt <= 8'(HOLD_CYCLES - 1);
            else if (state == HOLD && hold_cnt != '0)
                hold_cnt <= hold_cnt - 8'd1;

            if ((state == IDLE || state == HOLD) && start) begin
                idx      <= ioctl_index[0];
                dn_error <= 1'b0;
                dn_count <= '0;
            end
        end
    end

    assign ioctl_wait = mem_valid && !mem_ready;
    assign dn_active  = (state != IDLE);

endmodule

// File: tb/tb_dn_loader_ctrl.sv
// Directed bench for dn_loader_ctrl: hand sequences for reset, timing and hold
// length, plus a vector table for stall, range, drop and back-to-back cases.
module tb_dn_loader_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download, ioctl_wr, ioctl_wait;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout, ioctl_index;
    logic        mem_valid, mem_ready;
    logic [1:0]  mem_sel;
    logic [13:0] mem_addr;
    logic [7:0]  mem_data;
    logic        sys_reset, dn_active, dn_error;
    logic [24:0] dn_count;

    int passed = 0;
    int total  = 0;

    dn_loader_ctrl dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_data(mem_data), .sys_reset(sys_reset),
        .dn_active(dn_active), .dn_error(dn_error), .dn_count(dn_count)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        dl, wr;
        logic [24:0] addr;
        logic [7:0]  dout, idx;
        logic        rdy;
        logic        ev;
        logic [1:0]  esel;
        logic [13:0] eaddr;
        logic [7:0]  edata;
        logic        ew, esr, ee;
        logic [24:0] ec;
    } vec_t;

    vec_t vec[25];

    function automatic vec_t mk(int dl, int wr, int addr, int dout, int idx, int rdy,
                                int ev, int esel, int eaddr, int edata,
                                int ew, int esr, int ee, int ec);
        vec_t v;
        v.dl = 1'(dl);    v.wr = 1'(wr);        v.addr = 25'(addr);
        v.dout = 8'(dout); v.idx = 8'(idx);     v.rdy = 1'(rdy);
        v.ev = 1'(ev);    v.esel = 2'(esel);    v.eaddr = 14'(eaddr);
        v.edata = 8'(edata); v.ew = 1'(ew);     v.esr = 1'(esr);
        v.ee = 1'(ee);    v.ec = 25'(ec);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //            dl wr addr   dout  idx rdy | v sel eaddr  edata w sr e cnt
        vec[0]  = mk(0, 1, 9,     'hEE, 0, 1,   0, 1, 3,     'hA3, 0, 0, 0, 4); // wr ignored in IDLE
        vec[1]  = mk(1, 0, 0,     0,    1, 0,   0, 1, 3,     'hA3, 0, 1, 0, 0); // start font load
        vec[2]  = mk(1, 1, 5,     'h5C, 1, 0,   1, 2, 5,     'h5C, 1, 1, 0, 0);
        vec[3]  = mk(1, 0, 0,     0,    1, 0,   1, 2, 5,     'h5C, 1, 1, 0, 0);
        vec[4]  = mk(1, 0, 0,     0,    1, 0,   1, 2, 5,     'h5C, 1, 1, 0, 0);
        vec[5]  = mk(1, 0, 0,     0,    1, 0,   1, 2, 5,     'h5C, 1, 1, 0, 0);
        vec[6]  = mk(1, 0, 0,     0,    1, 0,   1, 2, 5,     'h5C, 1, 1, 0, 0);
        vec[7]  = mk(1, 0, 0,     0,    1, 1,   0, 2, 5,     'h5C, 0, 1, 0, 1); // stall released
        vec[8]  = mk(0, 0, 0,     0,    1, 1,   0, 2, 5,     'h5C, 0, 1, 0, 1); // -> DRAIN
        vec[9]  = mk(0, 0, 0,     0,    1, 1,   0, 2, 5,     'h5C, 0, 1, 0, 1); // -> HOLD
        vec[10] = mk(1, 0, 0,     0,    1, 1,   0, 2, 5,     'h5C, 0, 1, 0, 0); // HOLD -> LOAD
        vec[11] = mk(1, 1, 2048,  'h77, 1, 1,   0, 2, 5,     'h5C, 0, 1, 1, 0); // font limit
        vec[12] = mk(1, 1, 2047,  'h33, 1, 1,   1, 2, 2047,  'h33, 0, 1, 1, 0);
        vec[13] = mk(1, 0, 0,     0,    1, 1,   0, 2, 2047,  'h33, 0, 1, 1, 1);
        vec[14] = mk(0, 0, 0,     0,    1, 1,   0, 2, 2047,  'h33, 0, 1, 1, 1);
        vec[15] = mk(0, 0, 0,     0,    1, 1,   0, 2, 2047,  'h33, 0, 1, 1, 1);
        vec[16] = mk(1, 0, 0,     0,    0, 1,   0, 2, 2047,  'h33, 0, 1, 0, 0); // new load clears error
        vec[17] = mk(1, 1, 'h10,  'h11, 0, 0,   1, 1, 'h10,  'h11, 1, 1, 0, 0);
        vec[18] = mk(1, 1, 'h11,  'h22, 0, 0,   1, 1, 'h10,  'h11, 1, 1, 1, 0); // dropped while stalled
        vec[19] = mk(1, 0, 0,     0,    0, 1,   0, 1, 'h10,  'h11, 0, 1, 1, 1);
        vec[20] = mk(1, 1, 'h20,  'h44, 0, 1,   1, 1, 'h20,  'h44, 0, 1, 1, 1);
        vec[21] = mk(1, 1, 'h21,  'h45, 0, 1,   1, 1, 'h21,  'h45, 0, 1, 1, 2); // back-to-back
        vec[22] = mk(1, 1, 16383, 'h99, 0, 1,   1, 1, 16383, 'h99, 0, 1, 1, 3);
        vec[23] = mk(1, 1, 16384, 'hAA, 0, 1,   0, 1, 16383, 'h99, 0, 1, 1, 4); // BIOS limit
        vec[24] = mk(1, 1, 'h30,  'h55, 0, 0,   1, 1, 'h30,  'h55, 1, 1, 1, 4);

        reset = 1'b1; ioctl_download = 0; ioctl_wr = 0; ioctl_addr = '0;
        ioctl_dout = '0; ioctl_index = '0; mem_ready = 1'b1;

        // Reset state and release timing
        step(); step();
        check("rst sys_reset", 32'(sys_reset), 1);
        check("rst mem_valid", 32'(mem_valid), 0);
        check("rst dn_active", 32'(dn_active), 0);
        check("rst dn_error",  32'(dn_error), 0);
        check("rst dn_count",  32'(dn_count), 0);
        check("rst ioctl_wait", 32'(ioctl_wait), 0);
        check("rst mem_sel",   32'(mem_sel), 0);
        reset = 1'b0;
        #2 check("release sys_reset before edge", 32'(sys_reset), 1);
        step();
        check("release sys_reset after edge", 32'(sys_reset), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("idle mem_valid", 32'(mem_valid), 0);
        end

        // BIOS download, 4 bytes, one strobe every 4 cycles
        ioctl_download = 1; ioctl_index = 0;
        step();
        check("bios sys_reset", 32'(sys_reset), 1);
        check("bios dn_active", 32'(dn_active), 1);
        for (int k = 0; k < 4; k++) begin
            ioctl_wr = 1; ioctl_addr = 25'(k); ioctl_dout = 8'(8'hA0 + k);
            step();
            ioctl_wr = 0;
            check($sformatf("bios%0d valid", k), 32'(mem_valid), 1);
            check($sformatf("bios%0d sel", k),   32'(mem_sel), 1);
            check($sformatf("bios%0d addr", k),  32'(mem_addr), 32'(k));
            check($sformatf("bios%0d data", k),  32'(mem_data), 32'(8'hA0 + k));
            step();
            check($sformatf("bios%0d valid drop", k), 32'(mem_valid), 0);
            step(); step();
        end
        ioctl_download = 0;
        step();
        check("bios dn_count", 32'(dn_count), 4);
        check("bios dn_error", 32'(dn_error), 0);
        step();
        n = 0;
        while (sys_reset === 1'b1 && n < 100) begin
            n++;
            step();
        end
        check("bios hold cycles", 32'(n), 16);
        check("bios dn_active after hold", 32'(dn_active), 0);

        // Table-driven: stall, range limits, HOLD restart, drop, back-to-back
        for (int i = 0; i < 25; i++) begin
            ioctl_download = vec[i].dl; ioctl_wr = vec[i].wr; ioctl_addr = vec[i].addr;
            ioctl_dout = vec[i].dout; ioctl_index = vec[i].idx; mem_ready = vec[i].rdy;
            step();
            check($sformatf("r%0d valid", i),     32'(mem_valid), 32'(vec[i].ev));
            check($sformatf("r%0d sel", i),       32'(mem_sel), 32'(vec[i].esel));
            check($sformatf("r%0d addr", i),      32'(mem_addr), 32'(vec[i].eaddr));
            check($sformatf("r%0d data", i),      32'(mem_data), 32'(vec[i].edata));
            check($sformatf("r%0d wait", i),      32'(ioctl_wait), 32'(vec[i].ew));
            check($sformatf("r%0d sys_reset", i), 32'(sys_reset), 32'(vec[i].esr));
            check($sformatf("r%0d error", i),     32'(dn_error), 32'(vec[i].ee));
            check($sformatf("r%0d count", i),     32'(dn_count), 32'(vec[i].ec));
        end

        // Asynchronous reset mid-LOAD with a pending write
        #1 reset = 1'b1;
        #1;
        check("abort mem_valid", 32'(mem_valid), 0);
        check("abort ioctl_wait", 32'(ioctl_wait), 0);
        check("abort dn_active", 32'(dn_active), 0);
        check("abort sys_reset", 32'(sys_reset), 1);
        check("abort mem_addr", 32'(mem_addr), 0);
        check("abort dn_count", 32'(dn_count), 0);
        ioctl_wr = 0; ioctl_index = 2; ioctl_download = 1; mem_ready = 1;
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ioctl_wr = 1'(i % 2); ioctl_addr = 25'(i); ioctl_dout = 8'(i);
            step();
            check($sformatf("idx2 mem_valid %0d", i), 32'(mem_valid), 0);
            check($sformatf("idx2 sys_reset %0d", i), 32'(sys_reset), 0);
            check($sformatf("idx2 dn_active %0d", i), 32'(dn_active), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dn_loader_ctrl.md
Name: dn_loader_ctrl

Overview:
- Sequences HPS ioctl downloads (index 0 = BIOS, index 1 = font) into the system's BIOS ROM and font RAM write ports.
- Owns `sys_reset`: holds the system in reset for the whole download and for a fixed number of cycles afterwards.
- Buffers each ioctl byte in a 1-entry holding register, presents it to the memory port with a valid/ready handshake, and back-pressures HPS via `ioctl_wait`.
- Sits between `hps_io` and `system` in `emu`, replacing direct `dn_*` wiring.

Parameters:
- `ADDR_W`, 14, memory address width; `mem_addr` width.
- `BIOS_SIZE`, 16384, BIOS region size in bytes; writes at addr >= this are dropped.
- `FONT_SIZE`, 2048, font region size in bytes; writes at addr >= this are dropped.
- `HOLD_CYCLES`, 16, `sys_reset` extension after download ends (1..255).

Ports:
- `clk_sys`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `ioctl_download`  in  1  download in progress (from hps_io)
- `ioctl_wr`  in  1  single-cycle byte strobe
- `ioctl_addr`  in  25  byte address
- `ioctl_dout`  in  8  byte data
- `ioctl_index`  in  8  target select
- `ioctl_wait`  out  1  back-pressure to hps_io
- `mem_valid`  out  1  write request to memory
- `mem_ready`  in  1  memory accepts the write this cycle
- `mem_sel`  out  2  01 = BIOS, 10 = font, 00 = none
- `mem_addr`  out  ADDR_W  write address
- `mem_data`  out  8  write data
- `sys_reset`  out  1  reset to system
- `dn_active`  out  1  state != IDLE
- `dn_error`  out  1  sticky: an out-of-range byte was dropped during the last download
- `dn_count`  out  25  bytes accepted into memory during the last download

Behaviour:
- Reset values:
  - state = IDLE
  - `ioctl_wait` = 0, `mem_valid` = 0, `mem_sel` = 0, `mem_addr` = 0, `mem_data` = 0
  - `sys_reset` = 1
  - `dn_active` = 0, `dn_error` = 0, `dn_count` = 0
  - hold counter = 0
  - the first clock after reset release deasserts `sys_reset`.
- `sys_reset` is registered: 1 in LOAD and HOLD, 0 in IDLE.
- States:
  - IDLE: `ioctl_download` = 1 and `ioctl_index` < 2 → LOAD. The index is latched. `dn_error` and `dn_count` are cleared on the same edge. Any other index is ignored; the block stays IDLE.
  - LOAD: `ioctl_download` falls → DRAIN.
  - DRAIN: waits until the buffer is empty → HOLD, loading the hold counter with `HOLD_CYCLES` - 1.
  - HOLD: counter decrements each cycle. At 0 → IDLE, and `sys_reset` is 0 from the following cycle. A new `ioctl_download` with index < 2 in HOLD → LOAD directly (reset stays high; stats cleared).
- Buffer (LOAD and DRAIN only):
  - An `ioctl_wr` with addr < region size (BIOS_SIZE or FONT_SIZE per latched index) captures the byte. On the next edge: `mem_valid` = 1, `mem_addr` = `ioctl_addr[ADDR_W-1:0]`, `mem_data`, `mem_sel` = one-hot of the index.
  - An out-of-range `ioctl_wr` sets `dn_error` and does not load the buffer.
  - `mem_valid` with `mem_ready` high completes the transfer on that edge: `dn_count` +1, buffer empty. `mem_valid` drops the next cycle unless a new write is captured on the same edge (back-to-back: valid stays 1 with new data).
  - `mem_addr`, `mem_data` and `mem_sel` are stable while `mem_valid` = 1 and `mem_ready` = 0.
  - `ioctl_wait` = `mem_valid` & ~`mem_ready` (combinational).
- Protocol violation: an `ioctl_wr` that arrives while the buffer is full and not completing this cycle is dropped and sets `dn_error`. The buffer contents are preserved.
- `ioctl_wr` outside LOAD/DRAIN is ignored.
- `dn_count` saturates at all-ones.
- An asynchronous `reset` mid-LOAD aborts immediately: buffer discarded, all outputs return to reset values.

Test Plan:
- Reset then idle, `mem_ready` = 1 → `sys_reset` = 1 during reset, 0 one cycle after release; `mem_valid` never asserts.
- Index 0, 4 bytes at addr 0..3 (0xA0..0xA3), one `ioctl_wr` every 4 cycles, `mem_ready` = 1 → 4 writes with `mem_sel` = 01, each one cycle after its strobe. After download falls: `dn_count` = 4, `dn_error` = 0. `sys_reset` stays 1 for exactly 16 cycles after the drain, then 0.
- Index 1, `mem_ready` held 0 for 5 cycles after the first byte → `ioctl_wait` = 1 for those cycles with `mem_addr`/`mem_data` stable. The write completes when `mem_ready` rises; `dn_count` = 1.
- Index 1, write at addr 2048 (FONT_SIZE) → no `mem_valid`, `dn_error` = 1, `dn_count` = 0. A new download clears `dn_error`.
- Second `ioctl_wr` while stalled → second byte dropped, `dn_error` = 1, first byte written intact.
- `reset` asserted mid-LOAD with `mem_valid` = 1 → `mem_valid` drops asynchronously, state IDLE. Index 2 download afterwards → no activity, `sys_reset` = 0.
